alu_ctrl_fsm: RTL and testbench

Multi-cycle control unit and instruction decoder that drives the integer ALU's operand-select and function-code inputs.
- Accepts one 32-bit RV32 instruction per handshake.
- Sequences it through DECODE/EXEC/MEM/WB.
- Generates register-file, data-memory and PC control strobes.
- Sits between the instruction fetch stage and the datapath (ALU, register file, data memory).

---
 rtl/ctrl_pkg.sv | 123 ++++++++++++
 rtl/imm_gen.sv | 24 ++
 rtl/alu_ctrl_fsm.sv | 151 +++++++++++++++
 tb/tb_alu_ctrl_fsm.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - RV32 subset opcodes, ALU codes, FSM states and instruction decode helper
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_e;

    typedef enum logic [1:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B
    } imm_fmt_e;

    typedef enum logic [2:0] {
        C_ALU,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_ILLEGAL
    } instr_class_e;

    typedef struct packed {
        instr_class_e cls;
        logic         alu_sel;
        logic [3:0]   alu_fun;
        imm_fmt_e     fmt;
    } decode_t;

    // Anything not matched explicitly falls through as C_ILLEGAL
    function automatic decode_t decode(input logic [31:0] ir);
        decode_t    d;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ir[6:0];
        f3 = ir[14:12];
        f7 = ir[31:25];
        d.cls     = C_ILLEGAL;
        d.alu_sel = 1'b0;
        d.alu_fun = ALU_ADD;
        d.fmt     = IMM_NONE;
        case (op)
            OP_R: begin
                if (f7 == F7_BASE) begin
                    d.cls = C_ALU;
                    case (f3)
                        F3_ADD:  d.alu_fun = ALU_ADD;
                        F3_AND:  d.alu_fun = ALU_AND;
                        F3_XOR:  d.alu_fun = ALU_XOR;
                        F3_OR:   d.alu_fun = ALU_OR;
                        default: d.cls = C_ILLEGAL;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    d.cls     = C_ALU;
                    d.alu_fun = ALU_SUB;
                end
            end
            OP_I: begin
                d.cls     = C_ALU;
                d.alu_sel = 1'b1;
                d.fmt     = IMM_I;
                case (f3)
                    F3_ADD:  d.alu_fun = ALU_ADD;
                    F3_AND:  d.alu_fun = ALU_AND;
                    F3_XOR:  d.alu_fun = ALU_XOR;
                    F3_OR:   d.alu_fun = ALU_OR;
                    default: d.cls = C_ILLEGAL;
                endcase
            end
            OP_LOAD: begin
                if (f3 == F3_W) begin
                    d.cls     = C_LOAD;
                    d.alu_sel = 1'b1;
                    d.fmt     = IMM_I;
                end
            end
            OP_STORE: begin
                if (f3 == F3_W) begin
                    d.cls     = C_STORE;
                    d.alu_sel = 1'b1;
                    d.fmt     = IMM_S;
                end
            end
            OP_BRANCH: begin
                if (f3 == F3_BEQ) begin
                    d.cls     = C_BRANCH;
                    d.alu_fun = ALU_SUB;
                    d.fmt     = IMM_B;
                end
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - sign-extended immediate for I/S/B instruction formats
module imm_gen
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    // Bits [19:12] never contribute to an I/S/B immediate
    logic unused_bits;
    assign unused_bits = ^instr[19:12];

    always_comb begin
        imm = 32'd0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// rtl/alu_ctrl_fsm.sv - multi-cycle RV32 subset control unit driving ALU, register file, memory and PC
module alu_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_i,
    output logic        instr_ready_o,
    output logic        alu_sel_o,
    output logic [3:0]  alu_fun_o,
    output logic [31:0] imm_ext_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    output logic [4:0]  rd_addr_o,
    input  logic        alu_zero_i,
    output logic        reg_we_o,
    output logic        wb_sel_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    input  logic        mem_ack_i,
    output logic        pc_we_o,
    output logic        pc_src_o,
    output logic        illegal_o,
    output logic        mem_err_o
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_e       state;
    logic [31:0]  ir;
    instr_class_e cls_q;
    logic [TW-1:0] cnt;
    decode_t      dec;
    logic [31:0]  imm_d;
    logic         handshake;

    assign dec       = decode(ir);
    assign handshake = (state == S_FETCH) && instr_ready_o && instr_valid_i;

    imm_gen u_imm_gen (
        .instr (ir),
        .fmt   (dec.fmt),
        .imm   (imm_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_FETCH;
            ir            <= 32'd0;
            cls_q         <= C_ALU;
            cnt           <= '0;
            instr_ready_o <= 1'b0;
            alu_sel_o     <= 1'b0;
            alu_fun_o     <= ALU_ADD;
            imm_ext_o     <= 32'd0;
            rs1_addr_o    <= 5'd0;
            rs2_addr_o    <= 5'd0;
            rd_addr_o     <= 5'd0;
            reg_we_o      <= 1'b0;
            wb_sel_o      <= 1'b0;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            pc_we_o       <= 1'b0;
            pc_src_o      <= 1'b0;
            illegal_o     <= 1'b0;
            mem_err_o     <= 1'b0;
        end else begin
            instr_ready_o <= 1'b0;
            reg_we_o      <= 1'b0;
            wb_sel_o      <= 1'b0;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            pc_we_o       <= 1'b0;
            pc_src_o      <= 1'b0;
            illegal_o     <= 1'b0;
            mem_err_o     <= 1'b0;
            case (state)
                // Ready rises one cycle into FETCH so a new word is never taken alongside pc_we_o
                S_FETCH: begin
                    if (handshake) begin
                        ir    <= instr_i;
                        state <= S_DECODE;
                    end else begin
                        instr_ready_o <= 1'b1;
                    end
                end
                S_DECODE: begin
                    alu_sel_o  <= dec.alu_sel;
                    alu_fun_o  <= dec.alu_fun;
                    imm_ext_o  <= imm_d;
                    rs1_addr_o <= ir[19:15];
                    rs2_addr_o <= ir[24:20];
                    rd_addr_o  <= ir[11:7];
                    cls_q      <= dec.cls;
                    if (dec.cls == C_ILLEGAL) begin
                        illegal_o <= 1'b1;
                        pc_we_o   <= 1'b1;
                        state     <= S_FETCH;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (cls_q)
                        C_LOAD, C_STORE: begin
                            mem_req_o <= 1'b1;
                            mem_we_o  <= (cls_q == C_STORE);
                            cnt       <= '0;
                            state     <= S_MEM;
                        end
                        C_BRANCH: begin
                            pc_we_o  <= 1'b1;
                            pc_src_o <= alu_zero_i;
                            state    <= S_FETCH;
                        end
                        default: state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ack_i) begin
                        if (cls_q == C_STORE) begin
                            pc_we_o <= 1'b1;
                            state   <= S_FETCH;
                        end else begin
                            state <= S_WB;
                        end
                    end else if (MEM_TIMEOUT != 0 && cnt == TW'(MEM_TIMEOUT - 1)) begin
                        mem_err_o <= 1'b1;
                        pc_we_o   <= 1'b1;
                        state     <= S_FETCH;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        mem_req_o <= 1'b1;
                        mem_we_o  <= (cls_q == C_STORE);
                    end
                end
                S_WB: begin
                    reg_we_o <= (rd_addr_o != 5'd0);
                    wb_sel_o <= (cls_q == C_LOAD);
                    pc_we_o  <= 1'b1;
                    state    <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb/tb_alu_ctrl_fsm.sv - table-driven self-checking bench for alu_ctrl_fsm
module tb_alu_ctrl_fsm;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_valid_i;
    logic [31:0] instr_i;
    logic        instr_ready_o;
    logic        alu_sel_o;
    logic [3:0]  alu_fun_o;
    logic [31:0] imm_ext_o;
    logic [4:0]  rs1_addr_o;
    logic [4:0]  rs2_addr_o;
    logic [4:0]  rd_addr_o;
    logic        alu_zero_i;
    logic        reg_we_o;
    logic        wb_sel_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic        mem_ack_i;
    logic        pc_we_o;
    logic        pc_src_o;
    logic        illegal_o;
    logic        mem_err_o;

    always #5 clk_i = ~clk_i;

    alu_ctrl_fsm #(.MEM_TIMEOUT(16)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .instr_valid_i (instr_valid_i),
        .instr_i       (instr_i),
        .instr_ready_o (instr_ready_o),
        .alu_sel_o     (alu_sel_o),
        .alu_fun_o     (alu_fun_o),
        .imm_ext_o     (imm_ext_o),
        .rs1_addr_o    (rs1_addr_o),
        .rs2_addr_o    (rs2_addr_o),
        .rd_addr_o     (rd_addr_o),
        .alu_zero_i    (alu_zero_i),
        .reg_we_o      (reg_we_o),
        .wb_sel_o      (wb_sel_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_ack_i     (mem_ack_i),
        .pc_we_o       (pc_we_o),
        .pc_src_o      (pc_src_o),
        .illegal_o     (illegal_o),
        .mem_err_o     (mem_err_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          ack_wait;
        logic        chk_fields;
        logic [3:0]  fun;
        logic        sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        int          lat;
        int          reg_we;
        logic        wb_sel;
        int          req;
        int          mem_we;
        int          ill;
        int          err;
        logic        pc_src;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [31:0] instr, input logic zero, input int ack_wait,
                                input logic chk_fields, input logic [3:0] fun, input logic sel,
                                input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input int lat, input int reg_we, input logic wb_sel,
                                input int req, input int mem_we, input int ill, input int err,
                                input logic pc_src);
        vec_t v;
        v.instr = instr; v.zero = zero; v.ack_wait = ack_wait; v.chk_fields = chk_fields;
        v.fun = fun; v.sel = sel; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.lat = lat; v.reg_we = reg_we; v.wb_sel = wb_sel; v.req = req; v.mem_we = mem_we;
        v.ill = ill; v.err = err; v.pc_src = pc_src;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int w;
        w = 0;
        while (!instr_ready_o && w < 20) begin
            @(negedge clk_i);
            w++;
        end
        chk(name, instr_ready_o, 1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   lat, nreg, nreq, nwe, nill, nerr, nrdy;
        logic wbs, pcsrc, rdy_after, pc_after;
        logic [3:0]  fun;
        logic        sel;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        string p;
        p = $sformatf("v%0d_", idx);
        lat = 0; nreg = 0; nreq = 0; nwe = 0; nill = 0; nerr = 0; nrdy = 0;
        wbs = 0; pcsrc = 0; rdy_after = 0; pc_after = 1;
        fun = 0; sel = 0; imm = 0; rs1 = 0; rs2 = 0; rd = 0;
        wait_ready({p, "ready_wait"});
        instr_i       = v.instr;
        instr_valid_i = 1'b1;
        alu_zero_i    = v.zero;
        mem_ack_i     = 1'b0;
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk_i);
            if (lat != 0 && c == lat + 1) begin
                rdy_after = instr_ready_o;
                pc_after  = pc_we_o;
                break;
            end
            if (instr_ready_o) nrdy++;
            if (reg_we_o) begin nreg++; wbs = wb_sel_o; end
            if (mem_req_o) nreq++;
            if (mem_we_o) nwe++;
            if (illegal_o) nill++;
            if (mem_err_o) nerr++;
            mem_ack_i = (v.ack_wait != 0) && mem_req_o && (nreq == v.ack_wait);
            if (pc_we_o && lat == 0) begin
                lat = c; pcsrc = pc_src_o;
                fun = alu_fun_o; sel = alu_sel_o; imm = imm_ext_o;
                rs1 = rs1_addr_o; rs2 = rs2_addr_o; rd = rd_addr_o;
            end
        end
        mem_ack_i = 1'b0;
        chk({p, "latency"}, lat, v.lat);
        chk({p, "reg_we_count"}, nreg, v.reg_we);
        chk({p, "wb_sel"}, wbs, v.wb_sel);
        chk({p, "mem_req_cycles"}, nreq, v.req);
        chk({p, "mem_we_cycles"}, nwe, v.mem_we);
        chk({p, "illegal_count"}, nill, v.ill);
        chk({p, "mem_err_count"}, nerr, v.err);
        chk({p, "pc_src"}, pcsrc, v.pc_src);
        chk({p, "pc_we_single"}, pc_after, 0);
        chk({p, "ready_early"}, nrdy, 0);
        chk({p, "ready_after"}, rdy_after, 1);
        if (v.chk_fields) begin
            chk({p, "alu_fun"}, fun, v.fun);
            chk({p, "alu_sel"}, sel, v.sel);
            chk({p, "imm_ext"}, imm, v.imm);
            chk({p, "rs1"}, rs1, v.rs1);
            chk({p, "rs2"}, rs2, v.rs2);
            chk({p, "rd"}, rd, v.rd);
        end
    endtask

    initial begin
        //             instr         z  ack chk fun sel imm            rs1 rs2 rd lat reg wb req we ill err src
        vecs.push_back(mk(32'h002081B3, 0, 0, 1, 4'h0, 0, 32'h00000000, 1, 2, 3, 4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h407302B3, 0, 0, 1, 4'h1, 0, 32'h00000000, 6, 7, 5, 4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'hFFF00093, 0, 0, 1, 4'h0, 1, 32'hFFFFFFFF, 0, 31, 1, 4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'hFFF00013, 0, 0, 1, 4'h0, 1, 32'hFFFFFFFF, 0, 31, 0, 4, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h8002C313, 0, 0, 1, 4'h3, 1, 32'hFFFFF800, 5, 0, 6, 4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h009473B3, 0, 0, 1, 4'h2, 0, 32'h00000000, 8, 9, 7, 4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h00C5E533, 0, 0, 1, 4'h4, 0, 32'h00000000, 11, 12, 10, 4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h7FF0E093, 0, 0, 1, 4'h4, 1, 32'h000007FF, 1, 31, 1, 4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h00812203, 0, 3, 1, 4'h0, 1, 32'h00000008, 2, 8, 4, 7, 1, 1, 3, 0, 0, 0, 0));
        vecs.push_back(mk(32'h00812203, 0, 0, 1, 4'h0, 1, 32'h00000008, 2, 8, 4, 19, 0, 0, 16, 0, 0, 1, 0));
        vecs.push_back(mk(32'h00512623, 0, 1, 1, 4'h0, 1, 32'h0000000C, 2, 5, 12, 4, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(32'h00512623, 0, 2, 1, 4'h0, 1, 32'h0000000C, 2, 5, 12, 5, 0, 0, 2, 2, 0, 0, 0));
        vecs.push_back(mk(32'h00208863, 1, 0, 1, 4'h1, 0, 32'h00000010, 1, 2, 16, 3, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(32'h00208863, 0, 0, 1, 4'h1, 0, 32'h00000010, 1, 2, 16, 3, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'hFE418CE3, 1, 0, 1, 4'h1, 0, 32'hFFFFFFF8, 3, 4, 25, 3, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(32'h00000000, 0, 0, 0, 4'h0, 0, 32'h00000000, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(32'h4020F1B3, 0, 0, 0, 4'h0, 0, 32'h00000000, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(32'h00810203, 0, 0, 0, 4'h0, 0, 32'h00000000, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(32'h00109093, 0, 0, 0, 4'h0, 0, 32'h00000000, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0));

        rst_i = 1'b1; instr_valid_i = 1'b0; instr_i = 32'd0; alu_zero_i = 1'b0; mem_ack_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ready", instr_ready_o, 0);
        chk("rst_alu_fun", alu_fun_o, 0);
        chk("rst_imm", imm_ext_o, 0);
        chk("rst_strobes", {reg_we_o, pc_we_o, mem_req_o, mem_we_o, illegal_o, mem_err_o, wb_sel_o}, 0);
        chk("rst_fields", {alu_sel_o, rs1_addr_o, rs2_addr_o, rd_addr_o, pc_src_o}, 0);
        rst_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Reset while a store waits in MEM: no completion may leak out afterwards
        wait_ready("mr_ready_wait");
        instr_i = 32'h00512623; instr_valid_i = 1'b1; mem_ack_i = 1'b0;
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        for (int w = 0; w < 10 && !mem_req_o; w++) @(negedge clk_i);
        chk("mr_in_mem", {mem_req_o, mem_we_o}, 2'b11);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("mr_req_dropped", {mem_req_o, mem_we_o}, 0);
        chk("mr_no_pc_we", pc_we_o, 0);
        chk("mr_imm_cleared", imm_ext_o, 0);
        rst_i = 1'b0;
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        chk("mr_ready_after", instr_ready_o, 1);
        chk("mr_no_strobes", {pc_we_o, reg_we_o, mem_req_o}, 0);
        mem_ack_i = 1'b0;
        run_vec(99, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
